// File: rtl/pwm_pkg.sv
// Constants and state type shared by the PWM generator and capture blocks.
package pwm_pkg;

  localparam int SLOT_CYCLES = 100;
  localparam int SLOTS       = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser plus previous-level flop with rise/fall detection.
// primed goes high once the synchroniser holds a real sample after reset.
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic primed
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [1:0] warm_q, warm_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    warm_d  = warm_q;
    if (warm_q != 2'd2) begin
      warm_d = warm_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
    end
  end

  assign level  = sync2_q;
  assign rise   = sync2_q & ~prev_q;
  assign fall   = ~sync2_q & prev_q;
  assign primed = (warm_q == 2'd2);

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM signal, quantises the high
// time to the generator's slot code and flags stuck-high / stuck-low inputs.
module pwm_capture #(
  parameter int SLOT_CYCLES = pwm_pkg::SLOT_CYCLES,
  parameter int SLOTS       = pwm_pkg::SLOTS,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 4000
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic [4:0]       pulse_width,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  import pwm_pkg::*;

  localparam int               SUB_W   = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic level, rise, fall, primed;

  pwm_sync_edge u_sync (
    .clk    (clk_1MHz),
    .rst    (rst),
    .din    (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .primed (primed)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_snap_q, high_snap_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [4:0]       slot_q, slot_d;
  logic [4:0]       pw_snap_q, pw_snap_d;
  logic [CNT_W-1:0] period_cycles_q, period_cycles_d;
  logic [CNT_W-1:0] high_cycles_q, high_cycles_d;
  logic [4:0]       pulse_width_q, pulse_width_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;

  logic       timeout;
  logic [5:0] rounded;
  logic [4:0] pw_round;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    rounded  = {1'b0, slot_q} + ((sub_q >= SUB_W'(SLOT_CYCLES / 2)) ? 6'd1 : 6'd0);
    pw_round = (rounded > 6'(SLOTS)) ? 5'(SLOTS) : rounded[4:0];
    timeout  = ((state_q == HIGH) || (state_q == LOW)) && (period_cnt_q >= CNT_W'(TIMEOUT));
  end

  always_comb begin
    state_d         = state_q;
    period_cnt_d    = sat_inc(period_cnt_q);
    hi_cnt_d        = hi_cnt_q;
    high_snap_d     = high_snap_q;
    sub_d           = sub_q;
    slot_d          = slot_q;
    pw_snap_d       = pw_snap_q;
    period_cycles_d = period_cycles_q;
    high_cycles_d   = high_cycles_q;
    pulse_width_d   = pulse_width_q;
    meas_valid_d    = 1'b0;
    stuck_high_d    = stuck_high_q;
    stuck_low_d     = stuck_low_q;

    // Every rise restarts the measurement window and releases any stuck flag.
    if (rise) begin
      period_cnt_d = CNT_W'(1);
      hi_cnt_d     = CNT_W'(1);
      sub_d        = SUB_W'(1);
      slot_d       = 5'd0;
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (primed && (fall || !level)) state_d = ARMED;
      end
      ARMED: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          state_d     = LOW;
          high_snap_d = hi_cnt_q;
          pw_snap_d   = pw_round;
        end else if (!rise && !timeout) begin
          hi_cnt_d = sat_inc(hi_cnt_q);
          if (sub_q == SUB_W'(SLOT_CYCLES - 1)) begin
            sub_d = '0;
            if (slot_q != 5'(SLOTS)) slot_d = slot_q + 5'd1;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d         = HIGH;
          period_cycles_d = period_cnt_q;
          high_cycles_d   = high_snap_q;
          pulse_width_d   = pw_snap_q;
          meas_valid_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout && !rise && !fall) begin
      if (level) begin
        stuck_high_d  = 1'b1;
        pulse_width_d = 5'(SLOTS);
        state_d       = IDLE;
      end else begin
        stuck_low_d   = 1'b1;
        pulse_width_d = 5'd0;
        state_d       = ARMED;
      end
    end
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state_q         <= IDLE;
      period_cnt_q    <= '0;
      hi_cnt_q        <= '0;
      high_snap_q     <= '0;
      sub_q           <= '0;
      slot_q          <= '0;
      pw_snap_q       <= '0;
      period_cycles_q <= '0;
      high_cycles_q   <= '0;
      pulse_width_q   <= '0;
      meas_valid_q    <= 1'b0;
      stuck_high_q    <= 1'b0;
      stuck_low_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      period_cnt_q    <= period_cnt_d;
      hi_cnt_q        <= hi_cnt_d;
      high_snap_q     <= high_snap_d;
      sub_q           <= sub_d;
      slot_q          <= slot_d;
      pw_snap_q       <= pw_snap_d;
      period_cycles_q <= period_cycles_d;
      high_cycles_q   <= high_cycles_d;
      pulse_width_q   <= pulse_width_d;
      meas_valid_q    <= meas_valid_d;
      stuck_high_q    <= stuck_high_d;
      stuck_low_q     <= stuck_low_d;
    end
  end

  assign period_cycles = period_cycles_q;
  assign high_cycles   = high_cycles_q;
  assign pulse_width   = pulse_width_q;
  assign meas_valid    = meas_valid_q;
  assign stuck_high    = stuck_high_q;
  assign stuck_low     = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed PWM stimulus with a scoreboard queue of expected measurements.
`timescale 1ns/1ps
module tb_pwm_capture;

  logic        clk;
  logic        rst;
  logic        pwm_in;
  logic [15:0] period_cycles;
  logic [15:0] high_cycles;
  logic [4:0]  pulse_width;
  logic        meas_valid;
  logic        stuck_high;
  logic        stuck_low;

  typedef struct {
    int p;
    int h;
    int pw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   have_prev = 0;
  int   prev_p = 0;
  int   prev_h = 0;
  int   prev_pw = 0;

  pwm_capture dut (
    .clk_1MHz      (clk),
    .rst           (rst),
    .pwm_in        (pwm_in),
    .period_cycles (period_cycles),
    .high_cycles   (high_cycles),
    .pulse_width   (pulse_width),
    .meas_valid    (meas_valid),
    .stuck_high    (stuck_high),
    .stuck_low     (stuck_low)
  );

  initial begin
    clk = 1'b0;
    forever #500 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every measurement strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      $display("meas: period=%0d high=%0d pulse_width=%0d", period_cycles, high_cycles, pulse_width);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: meas_valid=1 (period=%0d high=%0d pw=%0d), expected no measurement",
                 period_cycles, high_cycles, pulse_width);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("period_cycles", 32'(period_cycles), e.p);
        chk("high_cycles", 32'(high_cycles), e.h);
        chk("pulse_width", 32'(pulse_width), e.pw);
      end
    end
  end

  task automatic push_prev();
    if (have_prev != 0) exp_q.push_back('{p: prev_p, h: prev_h, pw: prev_pw});
  endtask

  // One PWM period: rise, h cycles high, p-h cycles low.
  task automatic pulse(input int h, input int p, input int pw, input bit chk_clear);
    push_prev();
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    if (chk_clear) begin
      chk("stuck_high_cleared", 32'(stuck_high), 0);
      chk("stuck_low_cleared", 32'(stuck_low), 0);
    end
    repeat (h - 3) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
    have_prev = 1;
    prev_h = h;
    prev_p = p;
    prev_pw = pw;
  endtask

  // A rise followed by a stuck level; flag expected exactly 4002 cycles after the rise is driven.
  task automatic stuck_seg(input bit lvl);
    int pub_p;
    int pub_h;
    pub_p = prev_p;
    pub_h = prev_h;
    push_prev();
    pwm_in = 1'b1;
    if (!lvl) begin
      repeat (400) @(negedge clk);
      pwm_in = 1'b0;
      repeat (3602) @(negedge clk);
    end else begin
      repeat (4002) @(negedge clk);
    end
    chk(lvl ? "stuck_high_early" : "stuck_low_early", lvl ? 32'(stuck_high) : 32'(stuck_low), 0);
    @(negedge clk);
    chk("stuck_high", 32'(stuck_high), 32'(lvl));
    chk("stuck_low", 32'(stuck_low), 32'(!lvl));
    chk("stuck_pulse_width", 32'(pulse_width), lvl ? 20 : 0);
    chk("stuck_period_kept", 32'(period_cycles), pub_p);
    chk("stuck_high_kept", 32'(high_cycles), pub_h);
    repeat (100) @(negedge clk);
    chk("stuck_flag_held", lvl ? 32'(stuck_high) : 32'(stuck_low), 1);
    if (lvl) begin
      pwm_in = 1'b0;
      repeat (1600) @(negedge clk);
    end
    have_prev = 0;
  endtask

  // Reset pulse 100 cycles into a high phase, released with the input still high.
  task automatic reset_seg();
    push_prev();
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_period", 32'(period_cycles), 0);
    chk("rst_high", 32'(high_cycles), 0);
    chk("rst_pw", 32'(pulse_width), 0);
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_stuck_high", 32'(stuck_high), 0);
    chk("rst_stuck_low", 32'(stuck_low), 0);
    rst = 1'b0;
    have_prev = 0;
    repeat (299) @(negedge clk);
    pwm_in = 1'b0;
    repeat (1600) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_period", 32'(period_cycles), 0);
    chk("init_high", 32'(high_cycles), 0);
    chk("init_pw", 32'(pulse_width), 0);
    chk("init_valid", 32'(meas_valid), 0);
    chk("init_stuck_high", 32'(stuck_high), 0);
    chk("init_stuck_low", 32'(stuck_low), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 3; i++) pulse(400, 2000, 4, 1'b0);
    for (int i = 0; i < 2; i++) pulse(1000, 2000, 10, 1'b0);
    for (int i = 0; i < 2; i++) pulse(1500, 2000, 15, 1'b0);
    pulse(449, 2000, 4, 1'b0);
    pulse(450, 2000, 5, 1'b0);
    pulse(2100, 3000, 20, 1'b0);
    pulse(400, 2000, 4, 1'b0);

    stuck_seg(1'b0);
    pulse(400, 2000, 4, 1'b1);
    pulse(400, 2000, 4, 1'b0);

    stuck_seg(1'b1);
    pulse(400, 2000, 4, 1'b1);
    pulse(400, 2000, 4, 1'b0);

    reset_seg();
    for (int i = 0; i < 3; i++) pulse(400, 2000, 4, 1'b0);

    push_prev();
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("pending_measurements", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
